wait_state_memory: RTL

Parametrised, multi-cycle data memory for the rv32 pipeline. It replaces the single-cycle data store with a request/ready handshake and a configurable wait-state count. It provides byte, half and word access with sign or zero extension, and reports misaligned accesses instead of silently corrupting memory. It sits between the core's load/store stage and the memory array; the core holds its pipeline with the `stall` output.

---
 rtl/wait_state_memory_if.sv | 23 ++
 rtl/wait_state_memory.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wait_state_memory_if.sv
// Request/ready bus between the core's load/store stage and the wait-state data memory.
interface wait_state_memory_if;
    logic        req;
    logic        we;
    logic [31:0] address;
    logic        usignext;
    logic [1:0]  width;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        ready;
    logic        misaligned;
    logic        stall;

    modport master (
        output req, we, address, usignext, width, wData,
        input  rData, ready, misaligned, stall
    );

    modport slave (
        input  req, we, address, usignext, width, wData,
        output rData, ready, misaligned, stall
    );
endinterface

// File: rtl/wait_state_memory.sv
// Multi-cycle data memory with LATENCY wait states, byte/half/word access with
// sign/zero extension, and misaligned-access reporting instead of a silent write.
module wait_state_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    wait_state_memory_if.slave memBus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic                  we_q;
    logic                  usignext_q;
    logic                  misPending_q;
    logic [1:0]            width_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wData_q;
    logic [31:0]           rData_q;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  commit;
    logic                  commitWrite;
    logic                  misDetect;
    logic                  readyInt;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [3:0]            laneEn;
    logic [31:0]           laneData;
    logic [31:0]           wordRead;
    logic [15:0]           shifted;
    logic [31:0]           loadValue;
    logic                  unusedAddrBits;

    // Upper address bits are deliberately dropped so the array wraps.
    assign unusedAddrBits = ^memBus.address[31:ADDR_WIDTH+2];

    always_comb begin
        misDetect = 1'b0;
        case (memBus.width)
            2'b01:   misDetect = memBus.address[0];
            2'b10:   misDetect = |memBus.address[1:0];
            2'b11:   misDetect = 1'b1;
            default: misDetect = 1'b0;
        endcase
    end

    // A misaligned request enters WAIT with a zero count, so it completes
    // on the next edge without consuming any wait states.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (memBus.req) begin
                    state_d = WAIT;
                    count_d = misDetect ? 4'd0 : 4'(LATENCY);
                end
            end
            WAIT: begin
                if (count_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    assign accept      = (state_q == IDLE) && memBus.req;
    assign commit      = (state_q == WAIT) && (count_q == 4'd0);
    assign commitWrite = commit && we_q && !misPending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            usignext_q   <= 1'b0;
            misPending_q <= 1'b0;
            width_q      <= 2'b00;
            addr_q       <= '0;
            wData_q      <= 32'd0;
        end else if (accept) begin
            we_q         <= memBus.we;
            usignext_q   <= memBus.usignext;
            misPending_q <= misDetect;
            width_q      <= memBus.width;
            addr_q       <= memBus.address[ADDR_WIDTH+1:0];
            wData_q      <= memBus.wData;
        end
    end

    assign wordIdx = addr_q[ADDR_WIDTH+1:2];

    always_comb begin
        laneEn   = 4'b0000;
        laneData = wData_q;
        case (width_q)
            2'b00: begin
                laneEn   = 4'b0001 << addr_q[1:0];
                laneData = {4{wData_q[7:0]}};
            end
            2'b01: begin
                laneEn   = addr_q[1] ? 4'b1100 : 4'b0011;
                laneData = {2{wData_q[15:0]}};
            end
            default: begin
                laneEn   = 4'b1111;
                laneData = wData_q;
            end
        endcase
    end

    // The array is never reset; only the addressed lanes change on a store.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (commitWrite && laneEn[lane]) begin
                mem[wordIdx][lane*8 +: 8] <= laneData[lane*8 +: 8];
            end
        end
    end

    assign wordRead = mem[wordIdx];
    assign shifted  = 16'(wordRead >> {addr_q[1:0], 3'b000});

    always_comb begin
        loadValue = wordRead;
        case (width_q)
            2'b00: begin
                loadValue = usignext_q ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                loadValue = usignext_q ? {16'd0, shifted}
                                       : {{16{shifted[15]}}, shifted};
            end
            default: begin
                loadValue = wordRead;
            end
        endcase
    end

    // Stores leave the previous load result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rData_q <= 32'd0;
        end else if (commit) begin
            if (misPending_q) begin
                rData_q <= 32'd0;
            end else if (!we_q) begin
                rData_q <= loadValue;
            end
        end
    end

    assign readyInt          = (state_q == DONE);
    assign memBus.ready      = readyInt;
    assign memBus.misaligned = readyInt & misPending_q;
    assign memBus.rData      = rData_q;
    assign memBus.stall      = memBus.req & ~readyInt;

endmodule
